// File: rtl/throttle_pkg.sv
// throttle_pkg: shared defaults and types for the pushbutton speed throttle.
// Holds the default half-period table (1..6 Hz at CLK_50 = 50 MHz), the
// default widths and the step encoding used by the level arbitration.
package throttle_pkg;

    localparam int NUM_LEVELS_DEF = 6;
    localparam int CNT_W_DEF      = 26;

    // Index 0 is the slowest level (1 Hz); each entry is CLK_50 cycles per half-period.
    localparam logic [NUM_LEVELS_DEF-1:0][CNT_W_DEF-1:0] HALF_P_DEF = {
        26'd4_166_667,   // level 5: 6 Hz
        26'd5_000_000,   // level 4: 5 Hz
        26'd6_250_000,   // level 3: 4 Hz
        26'd8_333_333,   // level 2: 3 Hz
        26'd12_500_000,  // level 1: 2 Hz
        26'd25_000_000   // level 0: 1 Hz
    };

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN
    } step_e;

endpackage

// File: rtl/throttle_ctrl_pb_conditioner.sv
// pb_conditioner: turns one raw, bouncy, asynchronous pushbutton into a
// single-cycle step request. Two-flop synchroniser, DB_LEN-sample debounce
// window with hysteresis, rising-edge pulse.
// Optional auto-repeat under THROTTLE_AUTOREPEAT_EN: while the debounced
// button stays high (and the other button is not held) a further request
// fires every REPEAT_CYCLES after the initial edge request.
module pb_conditioner #(
    parameter int DB_LEN        = 8,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic CLK_50,
    input  logic reset,
    input  logic pb,
`ifdef THROTTLE_AUTOREPEAT_EN
    input  logic hold_block,
    output logic level,
`endif
    output logic req
);

    logic [1:0]        sync_q;
    logic [DB_LEN-1:0] db_sr;
    logic              deb;
    logic              deb_q;
    logic              edge_req;

    // Synchronise, shift into the debounce window, and update the held debounced level
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            db_sr  <= '0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its source from before this edge
            sync_q <= {sync_q[0], pb};
            db_sr  <= {db_sr[DB_LEN-2:0], sync_q[1]};
            if (&db_sr)
                deb <= 1'b1;
            else if (~|db_sr)
                deb <= 1'b0;
            deb_q  <= deb;
        end
    end

    assign edge_req = deb & ~deb_q;

`ifdef THROTTLE_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_q;

    // Repeat timer: counts while held alone, emits a pulse every REPEAT_CYCLES
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
            rep_q   <= 1'b0;
        end else if (!deb || hold_block) begin
            rep_cnt <= '0;
            rep_q   <= 1'b0;
        end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
            rep_q   <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
            rep_q   <= 1'b0;
        end
    end

    assign req   = edge_req | (rep_q & deb & ~hold_block);
    assign level = deb;
`else
    assign req = edge_req;
`endif

endmodule

// File: rtl/throttle_ctrl.sv
// throttle_ctrl: pushbutton speed throttle. Two conditioned buttons step a
// saturating speed level; the level picks a half-period from HALF_P and a
// counter divides CLK_50 into a 50%-duty slow_clk plus a slow_tick pulse on
// each slow_clk rising edge. A level change restarts the half-period at once.
// Build option THROTTLE_AUTOREPEAT_EN enables auto-repeat in the conditioners.
module throttle_ctrl
    import throttle_pkg::*;
#(
    parameter int NUM_LEVELS    = NUM_LEVELS_DEF,
    parameter int LVL_W         = $clog2(NUM_LEVELS),
    parameter int CNT_W         = CNT_W_DEF,
    parameter logic [NUM_LEVELS-1:0][CNT_W-1:0] HALF_P = HALF_P_DEF,
    parameter int RESET_LEVEL   = 0,
    parameter int DB_LEN        = 8,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic             pb_freq_up,
    input  logic             pb_freq_dn,
    output logic             slow_clk,
    output logic             slow_tick,
    output logic [LVL_W-1:0] freq_num,
    output logic             level_chg
);

    localparam logic [LVL_W-1:0] TOP_LEVEL = LVL_W'(NUM_LEVELS - 1);

    logic             up_req;
    logic             dn_req;
    step_e            step;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_last;

`ifdef THROTTLE_AUTOREPEAT_EN
    logic up_level;
    logic dn_level;

    pb_conditioner #(.DB_LEN(DB_LEN), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .pb         (pb_freq_up),
        .hold_block (dn_level),
        .level      (up_level),
        .req        (up_req)
    );

    pb_conditioner #(.DB_LEN(DB_LEN), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .pb         (pb_freq_dn),
        .hold_block (up_level),
        .level      (dn_level),
        .req        (dn_req)
    );
`else
    pb_conditioner #(.DB_LEN(DB_LEN), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .CLK_50 (CLK_50),
        .reset  (reset),
        .pb     (pb_freq_up),
        .req    (up_req)
    );

    pb_conditioner #(.DB_LEN(DB_LEN), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
        .CLK_50 (CLK_50),
        .reset  (reset),
        .pb     (pb_freq_dn),
        .req    (dn_req)
    );
`endif

    // Step arbitration: one-sided requests only, and never past either end of the range
    always_comb begin
        // NOTE: default assigned first so no path leaves step unassigned (no latch)
        step = STEP_NONE;
        if (up_req && !dn_req && freq_num != TOP_LEVEL)
            step = STEP_UP;
        else if (dn_req && !up_req && freq_num != '0)
            step = STEP_DN;
    end

    // Level register with a one-cycle change pulse aligned to the new value
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            freq_num  <= LVL_W'(RESET_LEVEL);
            level_chg <= 1'b0;
        end else begin
            case (step)
                STEP_UP: freq_num <= freq_num + LVL_W'(1);
                STEP_DN: freq_num <= freq_num - LVL_W'(1);
                default: freq_num <= freq_num;
            endcase
            level_chg <= (step != STEP_NONE);
        end
    end

    assign half_last = HALF_P[freq_num] - CNT_W'(1);

    // Divider: toggle slow_clk at the end of each half-period; restart on a level change
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            slow_clk  <= 1'b0;
            slow_tick <= 1'b0;
        end else if (step != STEP_NONE) begin
            cnt       <= '0;
            slow_tick <= 1'b0;
        end else if (cnt == half_last) begin
            cnt       <= '0;
            slow_clk  <= ~slow_clk;
            slow_tick <= ~slow_clk;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            slow_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_throttle_ctrl.sv
// tb_throttle_ctrl: self-checking bench for throttle_ctrl with small sim
// parameters (DB_LEN=4, HALF_P={4,3,2,1,1,1}, REPEAT_CYCLES=20).
// Directed sequences and a press table cover timing, bounce, saturation,
// simultaneous presses, divider periods and reset; a randomized phase compares
// freq_num/level_chg against a sample-history reference model.
module tb_throttle_ctrl;

    localparam int NL = 6;
    localparam int LW = $clog2(NL);
    localparam int CW = 26;
    localparam int DB = 4;
    localparam int RC = 20;
    localparam logic [NL-1:0][CW-1:0] HP = {26'd1, 26'd1, 26'd1, 26'd2, 26'd3, 26'd4};

    logic          CLK_50     = 1'b0;
    logic          reset      = 1'b1;
    logic          pb_freq_up = 1'b0;
    logic          pb_freq_dn = 1'b0;
    logic          slow_clk;
    logic          slow_tick;
    logic [LW-1:0] freq_num;
    logic          level_chg;

    throttle_ctrl #(
        .NUM_LEVELS    (NL),
        .CNT_W         (CW),
        .HALF_P        (HP),
        .RESET_LEVEL   (0),
        .DB_LEN        (DB),
        .REPEAT_CYCLES (RC)
    ) dut (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .pb_freq_up (pb_freq_up),
        .pb_freq_dn (pb_freq_dn),
        .slow_clk   (slow_clk),
        .slow_tick  (slow_tick),
        .freq_num   (freq_num),
        .level_chg  (level_chg)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_model = 1'b0;
    bit prev_clk  = 1'b0;
    bit clk_rose  = 1'b0;

    // Reference model: raw sample history per button, debounced levels, level
    bit hu[$];
    bit hd[$];
    bit deb_u, deb_d, debp_u, debp_d;
    int level_m;
    bit chg_m;

    typedef struct {
        bit up;
        bit dn;
        int exp_level;
        int exp_chg;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hu.delete();
        hd.delete();
        for (int i = 0; i < 16; i++) begin
            hu.push_back(1'b0);
            hd.push_back(1'b0);
        end
        deb_u = 0; deb_d = 0; debp_u = 0; debp_d = 0;
        level_m = 0;
        chg_m = 0;
    endtask

    // Debounced level after this edge: decided by the DB samples taken 3..DB+2 edges ago
    function automatic bit win_val(input bit h[$], input bit cur);
        bit all1 = 1'b1;
        bit all0 = 1'b1;
        for (int i = 0; i < DB; i++) begin
            if (h[h.size() - 4 - i]) all0 = 1'b0;
            else                     all1 = 1'b0;
        end
        return all1 ? 1'b1 : (all0 ? 1'b0 : cur);
    endfunction

    task automatic model_edge(input bit up, input bit dn);
        bit req_u, req_d;
        req_u = deb_u & ~debp_u;
        req_d = deb_d & ~debp_d;
        chg_m = 0;
        if (req_u && !req_d && level_m < NL - 1) begin
            level_m++;
            chg_m = 1;
        end else if (req_d && !req_u && level_m > 0) begin
            level_m--;
            chg_m = 1;
        end
        hu.push_back(up);
        hd.push_back(dn);
        if (hu.size() > 16) void'(hu.pop_front());
        if (hd.size() > 16) void'(hd.pop_front());
        debp_u = deb_u;
        debp_d = deb_d;
        deb_u  = win_val(hu, deb_u);
        deb_d  = win_val(hd, deb_d);
    endtask

    // One clock cycle: drive at negedge, model the posedge, sample at the next negedge
    task automatic cyc(input bit up, input bit dn);
        pb_freq_up = up;
        pb_freq_dn = dn;
        @(posedge CLK_50);
        model_edge(up, dn);
        @(negedge CLK_50);
        clk_rose = slow_clk && !prev_clk;
        prev_clk = slow_clk;
        check("slow_tick_on_rise", 32'(slow_tick), 32'(clk_rose));
        if (cmp_model) begin
            check("rand_freq_num", 32'(freq_num), level_m);
            check("rand_level_chg", 32'(level_chg), 32'(chg_m));
        end
    endtask

    task automatic do_reset();
        pb_freq_up = 0;
        pb_freq_dn = 0;
        reset = 1'b1;
        repeat (2) @(negedge CLK_50);
        reset = 1'b0;
        model_reset();
        prev_clk = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int rel, output int chg);
        chg = 0;
        for (int i = 0; i < hold; i++) begin cyc(up, dn); chg += int'(level_chg); end
        for (int i = 0; i < rel; i++)  begin cyc(0, 0);   chg += int'(level_chg); end
    endtask

    task automatic measure(input int exp_period, input string name);
        bit ok = 0;
        int n = 0;
        int ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0);
            if (clk_rose) begin ok = 1; break; end
        end
        check({name, "_first_rise"}, 32'(ok), 1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0);
            n++;
            ticks += int'(slow_tick);
            if (clk_rose) begin ok = 1; break; end
        end
        check({name, "_period"}, ok ? n : -1, exp_period);
        check({name, "_ticks"}, ticks, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg, n, ep_len;
        bit v, found, u, d;

        vecs[0]  = '{1, 0, 1, 1};
        vecs[1]  = '{1, 0, 2, 1};
        vecs[2]  = '{1, 0, 3, 1};
        vecs[3]  = '{1, 0, 4, 1};
        vecs[4]  = '{1, 0, 5, 1};
        vecs[5]  = '{1, 0, 5, 0};
        vecs[6]  = '{1, 0, 5, 0};
        vecs[7]  = '{1, 0, 5, 0};
        vecs[8]  = '{0, 1, 4, 1};
        vecs[9]  = '{1, 1, 4, 0};
        vecs[10] = '{0, 1, 3, 1};
        vecs[11] = '{0, 1, 2, 1};
        vecs[12] = '{0, 1, 1, 1};
        vecs[13] = '{0, 1, 0, 1};
        vecs[14] = '{0, 1, 0, 0};

        // Reset state
        model_reset();
        @(negedge CLK_50);
        check("rst_freq_num", 32'(freq_num), 0);
        check("rst_slow_clk", 32'(slow_clk), 0);
        check("rst_slow_tick", 32'(slow_tick), 0);
        check("rst_level_chg", 32'(level_chg), 0);
        reset = 1'b0;

        // Clean press: level changes exactly at edge k+3+DB, single step
        chg = 0;
        for (int j = 1; j <= 10; j++) begin
            cyc(1, 0);
            chg += int'(level_chg);
            if (j == 3 + DB) check("press_before_edge", 32'(freq_num), 0);
            if (j == 4 + DB) begin
                check("press_at_edge", 32'(freq_num), 1);
                check("press_chg_pulse", 32'(level_chg), 1);
            end
        end
        for (int j = 0; j < 12; j++) begin cyc(0, 0); chg += int'(level_chg); end
        check("press_single_step", chg, 1);
        check("press_final_level", 32'(freq_num), 1);

        // Bounce: short pulses never make it through the debounce window
        chg = 0;
        for (int p = 0; p < 5; p++) begin
            repeat (3) begin cyc(1, 0); chg += int'(level_chg); end
            repeat (3) begin cyc(0, 0); chg += int'(level_chg); end
        end
        repeat (12) begin cyc(0, 0); chg += int'(level_chg); end
        check("bounce_no_chg", chg, 0);
        check("bounce_level", 32'(freq_num), 1);

        // Press table: saturation at both ends and simultaneous presses
        do_reset();
        foreach (vecs[i]) begin
            press(vecs[i].up, vecs[i].dn, 10, 12, chg);
            check($sformatf("vec%0d_level", i), 32'(freq_num), vecs[i].exp_level);
            check($sformatf("vec%0d_chg", i), chg, vecs[i].exp_chg);
        end

        // Divider at level 0
        measure(8, "per_l0");

        // Level change keeps slow_clk and restarts the half-period
        found = 0;
        for (int i = 0; i < 20; i++) begin
            v = slow_clk;
            cyc(1, 0);
            if (level_chg) begin
                found = 1;
                check("chg_keeps_clk", 32'(slow_clk), 32'(v));
                break;
            end
        end
        check("chg_seen", 32'(found), 1);
        n = -1;
        v = slow_clk;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0);
            if (slow_clk != v) begin n = i; break; end
        end
        check("chg_restarts_cnt", n, 3);
        repeat (12) cyc(0, 0);
        check("div_level1", 32'(freq_num), 1);
        measure(6, "per_l1");
        press(1, 0, 10, 12, chg);
        measure(4, "per_l2");
        press(1, 0, 10, 12, chg);
        measure(2, "per_l3");

        // Reset mid-run while slow_clk is high
        check("pre_reset_level", 32'(freq_num), 3);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (slow_clk) begin found = 1; break; end
            cyc(0, 0);
        end
        check("pre_reset_clk_high", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_freq_num", 32'(freq_num), 0);
        check("midrst_slow_clk", 32'(slow_clk), 0);
        check("midrst_slow_tick", 32'(slow_tick), 0);
        check("midrst_level_chg", 32'(level_chg), 0);
        @(negedge CLK_50);
        @(negedge CLK_50);
        reset = 1'b0;
        model_reset();
        prev_clk = 1'b0;

        // Long hold: auto-repeat steps at +0, +20, +40 when enabled, else one step
        press(1, 0, 3 + DB + 50, 12, chg);
`ifdef THROTTLE_AUTOREPEAT_EN
        check("hold_steps", chg, 3);
        check("hold_level", 32'(freq_num), 3);
`else
        check("hold_steps", chg, 1);
        check("hold_level", 32'(freq_num), 1);
`endif

        // Randomized episodes against the reference model
        do_reset();
        cmp_model = 1'b1;
        for (int ep = 0; ep < 120; ep++) begin
            ep_len = $urandom_range(1, 14);
            u = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            for (int i = 0; i < ep_len; i++) begin
                if ($urandom_range(0, 3) == 0) u = ~u;
                if ($urandom_range(0, 3) == 0) d = ~d;
                cyc(u, d);
            end
            repeat (12) cyc(0, 0);
        end
        cmp_model = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
